rcs_restoring_div: RTL

- Sequential unsigned restoring divider, W bits.
- Sits directly downstream of the ripple-carry subtractor: it consumes one subtractor diff/borrow result per clock to produce one quotient bit.
- It is the first multi-cycle arithmetic block in the Arithmetic_Logic set.
- It computes quotient and remainder with a start/busy/done handshake.

---
 rtl/rcs_restoring_div_pkg.sv | 16 +
 rtl/rcs_restoring_div_sub.sv | 30 +++
 rtl/rcs_restoring_div.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rcs_restoring_div_pkg.sv
// -----------------------------------------------------------------------------
// rcs_restoring_div_pkg
// Shared definitions for the restoring divider: FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package rcs_restoring_div_pkg;

  localparam int unsigned RCS_DIV_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/rcs_restoring_div_sub.sv
// -----------------------------------------------------------------------------
// rcs_sub_nbit
// Combinational N-bit ripple-borrow subtractor: diff = a - b (mod 2^N).
// Ports:
//   a, b    [N-1:0] in   minuend / subtrahend
//   diff    [N-1:0] out  a - b
//   borrow          out  1 iff a < b (unsigned)
// -----------------------------------------------------------------------------
module rcs_sub_nbit #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] bw;

  always_comb begin
    bw   = '0;
    diff = '0;
    for (int unsigned i = 0; i < N; i++) begin
      diff[i]  = a[i] ^ b[i] ^ bw[i];
      bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
    end
    borrow = bw[N];
  end

endmodule

// File: rtl/rcs_restoring_div.sv
// -----------------------------------------------------------------------------
// rcs_restoring_div
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: RCS_DIV_ZERO_CHECK_EN (fast-path divide-by-zero).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   request, sampled only when not busy
//   dividend [W] in   numerator, captured at accepted start
//   divisor  [W] in   denominator, captured at accepted start
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid from here on
//   quotient [W] out  floor(dividend / divisor)
//   remainder[W] out  dividend mod divisor
//   div_by_zero  out  divisor was zero (0 when the feature is disabled)
// -----------------------------------------------------------------------------
module rcs_restoring_div
  import rcs_restoring_div_pkg::*;
#(
  parameter int unsigned W = RCS_DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(W);

  div_state_e    state_q, state_d;
  logic [W:0]    r_q, r_d;        // partial remainder
  logic [W-1:0]  q_q, q_d;        // dividend shifting out / quotient shifting in
  logic [W:0]    d_q, d_d;        // zero-extended divisor
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    s_w;
  logic [W:0]    t_w;
  logic          brw_w;

  // After each restore step R < D <= 2^W, so R[W] never feeds the next shift.
  logic          unused_r_top;
  assign unused_r_top = r_q[W];

  assign s_w = {r_q[W-1:0], q_q[W-1]};

  rcs_sub_nbit #(
    .N (W + 1)
  ) u_sub (
    .a      (s_w),
    .b      (d_q),
    .diff   (t_w),
    .borrow (brw_w)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = {1'b0, divisor};
          cnt_d   = CW'(W - 1);
          state_d = RUN;
          dbz_d   = 1'b0;
`ifdef RCS_DIV_ZERO_CHECK_EN
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!brw_w) begin
          r_d = t_w;
          q_d = {q_q[W-2:0], 1'b1};
        end else begin
          r_d = s_w;
          q_d = {q_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          // Publish on the final iteration so results are valid in DONE.
          cnt_d   = '0;
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

`ifdef RCS_DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`else
  logic unused_dbz;
  assign unused_dbz  = dbz_q;
  assign div_by_zero = 1'b0;
`endif

endmodule
